// File: rtl/cmac_tx_sf_fifo.sv
// Store-and-forward TX FIFO in front of the CMAC LBUS adapter: only whole packets are released downstream.
// Optional statistics counters are built when CMAC_TX_SF_STATS_EN is defined; otherwise they read as 0.
module cmac_tx_sf_fifo #(
  parameter int DEPTH = 512
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic [511:0]             S_TDATA,
  input  logic [63:0]              S_TSTRB,
  input  logic                     S_TVALID,
  input  logic                     S_TLAST,
  output logic                     S_TREADY,
  output logic [511:0]             M_TDATA,
  output logic [63:0]              M_TSTRB,
  output logic                     M_TVALID,
  output logic                     M_TLAST,
  input  logic                     M_TREADY,
  output logic [$clog2(DEPTH):0]   PKT_COUNT,
  output logic [31:0]              STAT_TX_PKTS,
  output logic [31:0]              STAT_DROP_PKTS,
  output logic [1:0]               o_dbg_wr_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 577;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_DROP  = 2'd2;

  localparam logic [AW:0]   PTR_ONE = 1;
  localparam logic [AW-1:0] CNT_ONE = 1;

  // Both sides use valid/ready: a beat moves on a rising CLK edge where valid
  // and ready are both high; valid never waits for ready, and a presented
  // beat is held unchanged until it is taken.

  logic [1:0]    r_wr_state;
  logic [AW-1:0] r_beat_cnt;
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_cmt_ptr;
  logic [AW:0]   r_rd_ptr;
  logic [AW:0]   r_free_ptr;
  logic [AW:0]   r_pkt_cnt;
  logic          r_rst_done;

  logic [EW-1:0] r_mem [DEPTH];
  logic [EW-1:0] r_rd_data;
  logic          r_rd_vld;
  logic [EW-1:0] r_q0;
  logic [EW-1:0] r_q1;
  logic [1:0]    r_q_cnt;

  logic          w_full;
  logic          w_s_ready;
  logic          w_s_acc;
  logic          w_wr_en;
  logic          w_commit;
  logic          w_to_drop;
  logic          w_m_valid;
  logic          w_pop;
  logic          w_pop_last;
  logic [2:0]    w_occ;
  logic          w_rd_en;

  // Fullness is measured against the oldest beat not yet taken downstream,
  // so words sitting in the prefetch still count as occupied.
  assign w_full     = (r_wr_ptr[AW] != r_free_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_free_ptr[AW-1:0]);
  assign w_s_ready  = r_rst_done && (!w_full || (r_wr_state == ST_DROP));
  assign w_s_acc    = S_TVALID && w_s_ready;
  assign w_wr_en    = w_s_acc && (r_wr_state != ST_DROP);
  assign w_commit   = w_wr_en && S_TLAST;
  assign w_to_drop  = w_s_acc && (r_wr_state == ST_WRITE) && !S_TLAST &&
                      (r_beat_cnt == '1);

  assign w_m_valid  = (r_q_cnt != 2'd0);
  assign w_pop      = w_m_valid && M_TREADY;
  assign w_pop_last = w_pop && r_q0[EW-1];

  // Prefetch credit: queued words plus the read in flight, after this cycle's pop.
  assign w_occ      = {1'b0, r_q_cnt} + {2'b00, r_rd_vld} - {2'b00, w_pop};
  assign w_rd_en    = (r_rd_ptr != r_cmt_ptr) && (w_occ < 3'd2);

  assign S_TREADY       = w_s_ready;
  assign M_TVALID       = w_m_valid;
  assign M_TDATA        = r_q0[511:0];
  assign M_TSTRB        = r_q0[575:512];
  assign M_TLAST        = r_q0[EW-1];
  assign PKT_COUNT      = r_pkt_cnt;
  assign o_dbg_wr_state = r_wr_state;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_rst_done <= 1'b0;
    end else begin
      r_rst_done <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_wr_state <= ST_IDLE;
      r_beat_cnt <= '0;
    end else begin
      case (r_wr_state)
        ST_IDLE: begin
          if (w_s_acc && !S_TLAST) begin
            r_wr_state <= ST_WRITE;
            r_beat_cnt <= CNT_ONE;
          end
        end
        ST_WRITE: begin
          if (w_s_acc) begin
            if (S_TLAST) begin
              r_wr_state <= ST_IDLE;
            end else if (r_beat_cnt == '1) begin
              r_wr_state <= ST_DROP;
            end else begin
              r_beat_cnt <= r_beat_cnt + CNT_ONE;
            end
          end
        end
        ST_DROP: begin
          if (w_s_acc && S_TLAST) begin
            r_wr_state <= ST_IDLE;
          end
        end
        default: r_wr_state <= ST_IDLE;
      endcase
    end
  end

  // A packet that outgrows the RAM is abandoned by pulling the working pointer back.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_wr_ptr  <= '0;
      r_cmt_ptr <= '0;
    end else begin
      if (w_to_drop) begin
        r_wr_ptr <= r_cmt_ptr;
      end else if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_commit) begin
        r_cmt_ptr <= r_wr_ptr + PTR_ONE;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr[AW-1:0]] <= {S_TLAST, S_TSTRB, S_TDATA};
    end
    if (w_rd_en) begin
      r_rd_data <= r_mem[r_rd_ptr[AW-1:0]];
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_rd_ptr   <= '0;
      r_free_ptr <= '0;
      r_rd_vld   <= 1'b0;
    end else begin
      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_free_ptr <= r_free_ptr + PTR_ONE;
      end
      r_rd_vld <= w_rd_en;
    end
  end

  // Two-entry prefetch queue; r_q0 is always the beat on the M_* outputs.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_q0    <= '0;
      r_q1    <= '0;
      r_q_cnt <= 2'd0;
    end else begin
      case ({r_rd_vld, w_pop})
        2'b11: begin
          if (r_q_cnt == 2'd1) begin
            r_q0 <= r_rd_data;
          end else begin
            r_q0 <= r_q1;
            r_q1 <= r_rd_data;
          end
        end
        2'b01: begin
          r_q0    <= r_q1;
          r_q_cnt <= r_q_cnt - 2'd1;
        end
        2'b10: begin
          if (r_q_cnt == 2'd0) begin
            r_q0 <= r_rd_data;
          end else begin
            r_q1 <= r_rd_data;
          end
          r_q_cnt <= r_q_cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_pkt_cnt <= '0;
    end else begin
      case ({w_commit, w_pop_last})
        2'b10:   r_pkt_cnt <= r_pkt_cnt + PTR_ONE;
        2'b01:   r_pkt_cnt <= r_pkt_cnt - PTR_ONE;
        default: ;
      endcase
    end
  end

`ifdef CMAC_TX_SF_STATS_EN
  logic [31:0] r_stat_tx;
  logic [31:0] r_stat_drop;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_stat_tx   <= '0;
      r_stat_drop <= '0;
    end else begin
      if (w_pop_last) begin
        r_stat_tx <= r_stat_tx + 32'd1;
      end
      if (w_to_drop) begin
        r_stat_drop <= r_stat_drop + 32'd1;
      end
    end
  end

  assign STAT_TX_PKTS   = r_stat_tx;
  assign STAT_DROP_PKTS = r_stat_drop;
`else
  assign STAT_TX_PKTS   = 32'd0;
  assign STAT_DROP_PKTS = 32'd0;
`endif

endmodule

// File: tb/tb_cmac_tx_sf_fifo.sv
// Bench for cmac_tx_sf_fifo (DEPTH=256): directed cases plus randomized traffic against a packet-level queue model.
module tb_cmac_tx_sf_fifo;

  localparam int DEPTH = 256;
  localparam int EW    = 577;

`ifdef CMAC_TX_SF_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST_N;
  logic [511:0]  S_TDATA;
  logic [63:0]   S_TSTRB;
  logic          S_TVALID;
  logic          S_TLAST;
  logic          S_TREADY;
  logic [511:0]  M_TDATA;
  logic [63:0]   M_TSTRB;
  logic          M_TVALID;
  logic          M_TLAST;
  logic          M_TREADY;
  logic [8:0]    PKT_COUNT;
  logic [31:0]   STAT_TX_PKTS;
  logic [31:0]   STAT_DROP_PKTS;
  logic [1:0]    dbg_wr_state;

  cmac_tx_sf_fifo #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .S_TDATA(S_TDATA), .S_TSTRB(S_TSTRB), .S_TVALID(S_TVALID), .S_TLAST(S_TLAST), .S_TREADY(S_TREADY),
    .M_TDATA(M_TDATA), .M_TSTRB(M_TSTRB), .M_TVALID(M_TVALID), .M_TLAST(M_TLAST), .M_TREADY(M_TREADY),
    .PKT_COUNT(PKT_COUNT), .STAT_TX_PKTS(STAT_TX_PKTS), .STAT_DROP_PKTS(STAT_DROP_PKTS),
    .o_dbg_wr_state(dbg_wr_state)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  // ---------------- reference model (packet level) ----------------
  logic [EW-1:0] exp_q[$];
  int            exp_cyc[$];
  logic [EW-1:0] cur_q[$];
  int            m_pkts    = 0;
  logic [31:0]   m_tx      = 0;
  logic [31:0]   m_drop    = 0;
  bit            m_in_drop = 0;
  bit            m_init    = 0;
  bit            m_exp_rdy = 0;
  int            m_cyc     = 0;

  always @(negedge CLK) begin
    logic [EW-1:0] b;
    if (m_init) begin
      chk("s_tready", S_TREADY, m_exp_rdy);
      chk("pkt_count", PKT_COUNT, m_pkts);
      chk("stat_tx", STAT_TX_PKTS, STATS_EN ? m_tx : 32'd0);
      chk("stat_drop", STAT_DROP_PKTS, STATS_EN ? m_drop : 32'd0);
      if (exp_q.size() == 0) chk("m_tvalid_idle", M_TVALID, 1'b0);
      else if (M_TVALID) chk("m_beat", {M_TLAST, M_TSTRB, M_TDATA}, exp_q[0]);
      else if (m_cyc - exp_cyc[0] >= 4) chk("m_tvalid_late", M_TVALID, 1'b1);
    end
    if (!RST_N) begin
      exp_q.delete(); exp_cyc.delete(); cur_q.delete();
      m_pkts = 0; m_tx = 0; m_drop = 0; m_in_drop = 0;
      m_init = 1; m_exp_rdy = 0;
    end else if (m_init) begin
      if (M_TVALID && M_TREADY && exp_q.size() > 0) begin
        b = exp_q.pop_front();
        void'(exp_cyc.pop_front());
        if (b[EW-1]) begin m_pkts--; m_tx++; end
      end
      if (S_TVALID && S_TREADY) begin
        if (m_in_drop) begin
          if (S_TLAST) m_in_drop = 0;
        end else begin
          cur_q.push_back({S_TLAST, S_TSTRB, S_TDATA});
          if (S_TLAST) begin
            for (int i = 0; i < cur_q.size(); i++) begin
              exp_q.push_back(cur_q[i]);
              exp_cyc.push_back(m_cyc);
            end
            cur_q.delete();
            m_pkts++;
          end else if (cur_q.size() == DEPTH) begin
            cur_q.delete();
            m_in_drop = 1;
            m_drop++;
          end
        end
      end
      m_exp_rdy = m_in_drop || ((exp_q.size() + cur_q.size()) < DEPTH);
    end
    m_cyc++;
  end

  // ---------------- driver tasks (all start and end at posedge+1) ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  function automatic logic [511:0] rand_data();
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [63:0] rand_last_strb();
    logic [63:0] m;
    int n;
    n = $urandom_range(1, 64);
    m = '1;
    m = m >> (64 - n);
    return m;
  endfunction

  task automatic send_beat(input logic [511:0] d, input logic [63:0] s, input bit l, output int waits);
    bit done;
    done = 0;
    waits = 0;
    S_TDATA = d; S_TSTRB = s; S_TLAST = l; S_TVALID = 1'b1;
    while (!done) begin
      @(negedge CLK);
      if (S_TREADY === 1'b1) done = 1;
      else begin
        waits++;
        if (waits > 4000) begin
          chk("s_tready_timeout", S_TREADY, 1'b1);
          S_TVALID = 1'b0;
          done = 1;
        end
      end
      @(posedge CLK);
      #1;
    end
    S_TVALID = 1'b0;
  endtask

  task automatic send_pkt(input int len, input int gap_pct, output int stalls);
    int w;
    bit last;
    stalls = 0;
    for (int i = 1; i <= len; i++) begin
      last = (i == len);
      send_beat(rand_data(), last ? rand_last_strb() : 64'hFFFF_FFFF_FFFF_FFFF, last, w);
      stalls += w;
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) tick($urandom_range(1, 2));
    end
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 5000) begin tick(1); k++; end
    if (k >= 5000) chk("drain_timeout", exp_q.size(), 0);
    tick(2);
  endtask

  task automatic wait_valid(input string name, output int k);
    k = 0;
    while (M_TVALID !== 1'b1 && k < 20) begin tick(1); k++; end
    if (k >= 20) chk(name, M_TVALID, 1'b1);
  endtask

  // ---------------- main sequence ----------------
  bit rnd_done;

  initial begin
    logic [511:0] d1;
    logic [31:0]  tx_before;
    int w, k, stalls;

    RST_N = 1'b0; S_TVALID = 1'b0; S_TLAST = 1'b0; S_TDATA = '0; S_TSTRB = '0; M_TREADY = 1'b0;
    tick(4);
    chk("rst_m_tvalid", M_TVALID, 1'b0);
    chk("rst_m_tlast", M_TLAST, 1'b0);
    chk("rst_m_tdata", M_TDATA, 512'd0);
    chk("rst_m_tstrb", M_TSTRB, 64'd0);
    chk("rst_s_tready", S_TREADY, 1'b0);
    chk("rst_pkt_count", PKT_COUNT, 9'd0);
    chk("rst_stat_tx", STAT_TX_PKTS, 32'd0);
    chk("rst_stat_drop", STAT_DROP_PKTS, 32'd0);
    RST_N = 1'b1;
    tick(1);
    chk("rel_s_tready", S_TREADY, 1'b1);

    // single-beat packet
    M_TREADY = 1'b1;
    d1 = rand_data();
    send_beat(d1, 64'hFFFF, 1'b1, w);
    chk("t1_pkt_count_up", PKT_COUNT, 9'd1);
    wait_valid("t1_valid_timeout", k);
    chk("t1_latency_le3", (k <= 3), 1'b1);
    chk("t1_data", M_TDATA, d1);
    chk("t1_strb", M_TSTRB, 64'hFFFF);
    chk("t1_last", M_TLAST, 1'b1);
    wait_drain();
    chk("t1_pkt_count_down", PKT_COUNT, 9'd0);

    // 4-beat packet with a 5-cycle hole after beat 2
    send_beat(rand_data(), 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, w);
    send_beat(rand_data(), 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, w);
    for (int i = 0; i < 5; i++) begin
      chk("t2_gap_no_valid", M_TVALID, 1'b0);
      tick(1);
    end
    send_beat(rand_data(), 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, w);
    send_beat(rand_data(), rand_last_strb(), 1'b1, w);
    wait_valid("t2_valid_timeout", k);
    for (int i = 0; i < 4; i++) begin
      chk("t2_consecutive", M_TVALID, 1'b1);
      tick(1);
    end
    wait_drain();

    // oversize packet dropped, exact-DEPTH packet and a 2-beat packet forwarded
    send_pkt(DEPTH + 10, 0, stalls);
    chk("t3_no_stall", stalls, 0);
    chk("t3_drop_stat", STAT_DROP_PKTS, STATS_EN ? 32'd1 : 32'd0);
    send_pkt(2, 0, stalls);
    wait_drain();
    send_pkt(DEPTH, 0, stalls);
    wait_drain();

    // fill with 2-beat packets while the sink is stalled
    M_TREADY = 1'b0;
    tx_before = STAT_TX_PKTS;
    for (int p = 0; p < 128; p++) send_pkt(2, 0, stalls);
    chk("t4_full_s_tready", S_TREADY, 1'b0);
    chk("t4_full_pkt_count", PKT_COUNT, 9'd128);
    M_TREADY = 1'b1;
    wait_drain();
    chk("t4_tx_delta", STAT_TX_PKTS - tx_before, STATS_EN ? 32'd128 : 32'd0);

    // commit and downstream tlast in the same cycle
    M_TREADY = 1'b0;
    send_pkt(2, 0, stalls);
    wait_valid("t5_valid_timeout", k);
    chk("t5_pre_count", PKT_COUNT, 9'd1);
    M_TREADY = 1'b1;
    tick(1);
    chk("t5_head_last", M_TLAST, 1'b1);
    send_beat(rand_data(), rand_last_strb(), 1'b1, w);
    chk("t5_same_cycle_count", PKT_COUNT, 9'd1);
    wait_drain();

    // reset in the middle of a packet with three packets stored
    M_TREADY = 1'b0;
    for (int p = 0; p < 3; p++) send_pkt(2, 0, stalls);
    send_beat(rand_data(), 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, w);
    send_beat(rand_data(), 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, w);
    RST_N = 1'b0;
    tick(1);
    RST_N = 1'b1;
    chk("t6_m_tvalid", M_TVALID, 1'b0);
    chk("t6_pkt_count", PKT_COUNT, 9'd0);
    chk("t6_s_tready_rst", S_TREADY, 1'b0);
    tick(1);
    chk("t6_s_tready_rel", S_TREADY, 1'b1);
    M_TREADY = 1'b1;
    send_pkt(3, 0, stalls);
    wait_drain();

    // randomized traffic with random sink backpressure
    rnd_done = 0;
    fork
      begin
        for (int p = 0; p < 40; p++) send_pkt((p == 20) ? 300 : $urandom_range(1, 12), 30, stalls);
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          M_TREADY = ($urandom_range(0, 3) != 0);
          tick(1);
        end
      end
    join
    M_TREADY = 1'b1;
    wait_drain();
    chk("end_exp_empty", exp_q.size(), 0);
    chk("end_pkt_count", PKT_COUNT, 9'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cmac_tx_sf_fifo.md
CMAC_TX_SF_FIFO -- requirements
Module: cmac_tx_sf_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 512: data-RAM depth in 512-bit words; power of two, minimum 256.
REQ-002 SHALL have port CLK, input, 1: sole clock; all logic is synchronous to it.
REQ-003 SHALL have port RST_N, input, 1: reset, synchronous, active-low.
REQ-004 SHALL have port S_TDATA, input, 512: upstream data; byte 0 in [7:0].
REQ-005 SHALL have port S_TSTRB, input, 64: upstream byte valid; contiguous from bit 0; all-ones except on tlast beats.
REQ-006 SHALL have ports S_TVALID (input, 1), S_TLAST (input, 1) and S_TREADY (output, 1): upstream AXI4-Stream handshake.
REQ-007 SHALL have ports M_TDATA (output, 512), M_TSTRB (output, 64), M_TVALID (output, 1), M_TLAST (output, 1) and M_TREADY (input, 1): downstream stream to the LBUS TX adapter.
REQ-008 SHALL have port PKT_COUNT, output, log2(DEPTH)+1: number of complete packets stored and not yet fully read.
REQ-009 SHALL have ports STAT_TX_PKTS (output, 32) and STAT_DROP_PKTS (output, 32): statistics counters.

Function
REQ-010 SHALL store each beat with {tdata, tstrb, tlast} in a DEPTH-entry RAM, written on S_TVALID&S_TREADY.
REQ-011 SHALL keep a committed write pointer, updated to the working write pointer +1 on an accepted tlast beat; the read side SHALL see only data below the committed pointer.
REQ-012 SHALL drive S_TREADY = 1 when the RAM is not full or the write FSM is in DROP; otherwise 0.
REQ-013 SHALL run the write FSM with states IDLE, WRITE and DROP: IDLE->WRITE on an accepted non-last beat; WRITE->IDLE on an accepted tlast; WRITE->DROP when the packet reaches DEPTH beats without tlast; DROP->IDLE on an accepted tlast.
REQ-014 On entry to DROP, SHALL rewind the working pointer to the committed pointer, discard all beats through tlast, and increment the drop count once.
REQ-015 SHALL accept and commit a single-beat packet (tvalid&tlast in IDLE) in one cycle.
REQ-016 SHALL assert M_TVALID for a packet's first beat no later than 3 cycles after its tlast is accepted.
REQ-017 Once the first beat is presented and M_TREADY stays 1, SHALL present every subsequent beat of that packet on consecutive cycles without deasserting M_TVALID; this requires a read prefetch of at least 2 entries.
REQ-018 SHALL hold M_* stable while M_TVALID=1 and M_TREADY=0.
REQ-019 SHALL increment PKT_COUNT on commit and decrement it on an accepted M_TLAST beat; when both occur in the same cycle it SHALL remain unchanged.
REQ-020 SHALL use wrap-around pointers of log2(DEPTH)+1 bits; full = MSBs differ and LSBs equal; empty = committed pointer equal to read pointer.
REQ-021 SHALL not reorder, truncate or alter beats of forwarded packets.

Reset
REQ-022 While RST_N=0 at a CLK edge, SHALL clear all pointers and PKT_COUNT, set the FSM to IDLE, and drive M_TVALID=0, M_TLAST=0, M_TDATA=0, M_TSTRB=0, S_TREADY=0 and both counters to 0.
REQ-023 Reset asserted mid-packet SHALL discard all stored and partial packets; a beat with S_TVALID=1 after release SHALL be treated as a new packet start.
REQ-024 SHALL drive S_TREADY=1 on the first cycle after RST_N returns high.

Configuration
REQ-025 Macro CMAC_TX_SF_STATS_EN defined: STAT_TX_PKTS SHALL increment on each accepted M_TLAST beat and STAT_DROP_PKTS on each DROP entry; both SHALL wrap at 2^32.
REQ-026 Macro CMAC_TX_SF_STATS_EN undefined: both counters SHALL be absent from the logic, their ports driven constant 0, and all other behaviour identical.

Verification
REQ-027 Send 1-beat packet, S_TSTRB=64'hFFFF, M_TREADY=1 -> one beat out within 3 cycles with same data, M_TLAST=1, PKT_COUNT 1->0.
REQ-028 Send 4-beat packet with a 5-cycle S_TVALID gap after beat 2 -> no M_TVALID until tlast accepted, then 4 consecutive valid beats.
REQ-029 Send a DEPTH+10-beat packet with DEPTH=256 -> S_TREADY stays 1, nothing forwarded, STAT_DROP_PKTS=1 (0 without macro), following 2-beat packet forwarded intact.
REQ-030 Hold M_TREADY=0, send 2-beat packets until S_TREADY=0 -> stall at 256 stored words, PKT_COUNT=128; release M_TREADY -> all 128 packets out in order, STAT_TX_PKTS=128.
REQ-031 Assert RST_N=0 for 1 cycle mid-packet with 3 packets stored -> M_TVALID=0, PKT_COUNT=0 next cycle; a new packet is then forwarded correctly.
REQ-032 Make commit and M_TLAST acceptance coincide in one cycle -> PKT_COUNT unchanged.
